// File: rtl/dvp_tb_pkg.sv
// Shared definitions for the DVP test-pattern generator: frame FSM states,
// pattern codes and the RGB565 colour-bar table.
package dvp_tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } state_t;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_HRAMP = 2'd1;
    localparam logic [1:0] PAT_VRAMP = 2'd2;
    localparam logic [1:0] PAT_FLAT  = 2'd3;

    // Index 0 (white) sits in the least significant slot.
    localparam logic [7:0][15:0] BAR_COLORS = {
        16'h0000,   // black
        16'h001F,   // blue
        16'hF800,   // red
        16'hF81F,   // magenta
        16'h07E0,   // green
        16'h07FF,   // cyan
        16'hFFE0,   // yellow
        16'hFFFF    // white
    };

    function automatic logic [15:0] gray_to_rgb565(input logic [7:0] g);
        return {g[7:3], g[7:2], g[7:3]};
    endfunction

endpackage

// File: rtl/dvp_pattern_rom.sv
// Combinational pixel generator: maps (x, y, pattern, byte select) to the
// DVP data byte. The parent registers the result.
module dvp_pattern_rom #(
    parameter int COLOR_MODE = 1,
    parameter int IM_X       = 1280,
    parameter int XW         = 11
) (
    input  logic [XW-1:0] x,
    input  logic [7:0]    y,
    input  logic [1:0]    pattern,
    input  logic          byte_sel,
    input  logic [7:0]    frame_cnt,
    output logic [7:0]    data_byte
);
    import dvp_tb_pkg::*;

    logic [2:0]  bar;
    logic [7:0]  gray;
    logic [15:0] pix;

    always_comb begin
        bar  = 3'((int'(x) * 8) / IM_X);
        gray = 8'h00;
        pix  = 16'h0000;
        case (pattern)
            PAT_BARS:  pix  = BAR_COLORS[bar];
            PAT_HRAMP: gray = 8'(x);
            PAT_VRAMP: gray = y;
            PAT_FLAT:  gray = frame_cnt;
            default:   gray = 8'h00;
        endcase
        if (pattern != PAT_BARS)
            pix = gray_to_rgb565(gray);

        // In 8-bit mode the bars fall back to the colour's high byte.
        if (COLOR_MODE == 1)
            data_byte = byte_sel ? pix[7:0] : pix[15:8];
        else
            data_byte = (pattern == PAT_BARS) ? pix[15:8] : gray;
    end

endmodule

// File: rtl/dvp_pattern_gen.sv
// DVP camera-timing test-pattern source (VSYNC/HREF/data).
// Optional DVP_PATGEN_SHORT_LINE_EN adds inject_short to shorten one active line.
module dvp_pattern_gen #(
    parameter int COLOR_MODE  = 1,
    parameter int IM_X        = 1280,
    parameter int IM_Y        = 720,
    parameter int HBLANK_CLKS = 64,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 5,
    parameter int VFP_LINES   = 5
) (
    input  logic       PCLK_cam,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
`ifdef DVP_PATGEN_SHORT_LINE_EN
    input  logic       inject_short,
`endif
    output logic [7:0] data_cam,
    output logic       VSYNC_cam,
    output logic       HREF_cam,
    output logic [7:0] frame_cnt,
    output logic       frame_done
);
    import dvp_tb_pkg::*;

    localparam int BPP   = (COLOR_MODE == 1) ? 2 : 1;
    localparam int HACT  = IM_X * BPP;
    localparam int LP    = HACT + HBLANK_CLKS;
    localparam int HCW   = $clog2(LP + 1);
    localparam int MAX_A = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
    localparam int MAX_B = (IM_Y > VFP_LINES) ? IM_Y : VFP_LINES;
    localparam int MAXL  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LCW   = $clog2(MAXL + 1);
    localparam int XW    = $clog2(IM_X + 1);

    localparam logic [HCW-1:0] H_LAST = HCW'(LP - 1);
    localparam logic [HCW-1:0] H_ACT  = HCW'(HACT);
    localparam logic [LCW-1:0] L_VS   = LCW'(VSYNC_LINES - 1);
    localparam logic [LCW-1:0] L_VBP  = LCW'(VBP_LINES - 1);
    localparam logic [LCW-1:0] L_ACT  = LCW'(IM_Y - 1);
    localparam logic [LCW-1:0] L_VFP  = LCW'(VFP_LINES - 1);

    state_t         state_reg, state_next;
    logic [HCW-1:0] hcnt_reg, hcnt_next;
    logic [LCW-1:0] lcnt_reg, lcnt_next;
    logic [LCW-1:0] lines_last;
    logic           frame_end;
    logic [1:0]     pat_reg;
    logic [7:0]     data_reg, frame_cnt_reg;
    logic           vsync_reg, href_reg, frame_done_reg;
    logic [HCW-1:0] href_len;
    logic           href_next;
    logic [7:0]     rom_byte;

    always_comb begin
        case (state_reg)
            ST_VSYNC:  lines_last = L_VS;
            ST_VBP:    lines_last = L_VBP;
            ST_ACTIVE: lines_last = L_ACT;
            default:   lines_last = L_VFP;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        lcnt_next  = lcnt_reg;
        frame_end  = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (enable) begin
                state_next = ST_VSYNC;
                hcnt_next  = '0;
                lcnt_next  = '0;
            end
        end else if (hcnt_reg != H_LAST) begin
            hcnt_next = hcnt_reg + 1'b1;
        end else begin
            hcnt_next = '0;
            if (lcnt_reg != lines_last) begin
                lcnt_next = lcnt_reg + 1'b1;
            end else begin
                lcnt_next = '0;
                case (state_reg)
                    ST_VSYNC:  state_next = ST_VBP;
                    ST_VBP:    state_next = ST_ACTIVE;
                    ST_ACTIVE: state_next = ST_VFP;
                    default: begin
                        // End of front porch: enable decides whether another frame follows.
                        frame_end  = 1'b1;
                        state_next = enable ? ST_VSYNC : ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DVP_PATGEN_SHORT_LINE_EN
    localparam logic [HCW-1:0] H_SHORT = HCW'(HACT - BPP);

    logic short_armed_reg, short_line_reg, short_line_next, line_start;

    assign line_start      = (state_next == ST_ACTIVE) && (hcnt_next == '0);
    assign short_line_next = line_start ? short_armed_reg : short_line_reg;
    assign href_len        = short_line_next ? H_SHORT : H_ACT;

    // A pulse arriving on the very cycle a line starts applies to the next line.
    always_ff @(posedge PCLK_cam or negedge rst_n) begin
        if (!rst_n) begin
            short_armed_reg <= 1'b0;
            short_line_reg  <= 1'b0;
        end else begin
            if (inject_short)
                short_armed_reg <= 1'b1;
            else if (line_start)
                short_armed_reg <= 1'b0;
            short_line_reg <= short_line_next;
        end
    end
`else
    assign href_len = H_ACT;
`endif

    // Outputs are registered from next-cycle counters so they align with state_reg.
    assign href_next = (state_next == ST_ACTIVE) && (hcnt_next < href_len);

    dvp_pattern_rom #(
        .COLOR_MODE (COLOR_MODE),
        .IM_X       (IM_X),
        .XW         (XW)
    ) u_rom (
        .x          (XW'(hcnt_next >> (BPP - 1))),
        .y          (8'(lcnt_next)),
        .pattern    (pat_reg),
        .byte_sel   ((BPP == 2) ? hcnt_next[0] : 1'b0),
        .frame_cnt  (frame_cnt_reg),
        .data_byte  (rom_byte)
    );

    always_ff @(posedge PCLK_cam or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            hcnt_reg       <= '0;
            lcnt_reg       <= '0;
            pat_reg        <= 2'd0;
            data_reg       <= 8'h00;
            vsync_reg      <= 1'b0;
            href_reg       <= 1'b0;
            frame_cnt_reg  <= 8'h00;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hcnt_reg       <= hcnt_next;
            lcnt_reg       <= lcnt_next;
            vsync_reg      <= (state_next == ST_VSYNC);
            href_reg       <= href_next;
            data_reg       <= href_next ? rom_byte : 8'h00;
            frame_done_reg <= frame_end;
            if (frame_end)
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            if ((state_next == ST_VSYNC) && (state_reg != ST_VSYNC))
                pat_reg <= pattern_sel;
        end
    end

    assign data_cam   = data_reg;
    assign VSYNC_cam  = vsync_reg;
    assign HREF_cam   = href_reg;
    assign frame_cnt  = frame_cnt_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_dvp_pattern_gen.sv
// Scoreboard bench for dvp_pattern_gen: an RGB565 instance and an 8-bit instance
// share clock and reset; expected bytes are queued and popped by a monitor.
module tb_dvp_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en1, en2;
    logic [1:0] sel1, sel2;
    logic [7:0] data1, data2, fc1, fc2;
    logic       vs1, vs2, href1, href2, fd1, fd2;
`ifdef DVP_PATGEN_SHORT_LINE_EN
    logic       inj1, inj2;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    bit sb1_on, sb2_on;

    dvp_pattern_gen #(
        .COLOR_MODE(1), .IM_X(8), .IM_Y(4), .HBLANK_CLKS(4),
        .VSYNC_LINES(2), .VBP_LINES(1), .VFP_LINES(1)
    ) dut1 (
        .PCLK_cam(clk), .rst_n(rst_n), .enable(en1), .pattern_sel(sel1),
`ifdef DVP_PATGEN_SHORT_LINE_EN
        .inject_short(inj1),
`endif
        .data_cam(data1), .VSYNC_cam(vs1), .HREF_cam(href1),
        .frame_cnt(fc1), .frame_done(fd1)
    );

    dvp_pattern_gen #(
        .COLOR_MODE(2), .IM_X(8), .IM_Y(4), .HBLANK_CLKS(4),
        .VSYNC_LINES(2), .VBP_LINES(1), .VFP_LINES(1)
    ) dut2 (
        .PCLK_cam(clk), .rst_n(rst_n), .enable(en2), .pattern_sel(sel2),
`ifdef DVP_PATGEN_SHORT_LINE_EN
        .inject_short(inj2),
`endif
        .data_cam(data2), .VSYNC_cam(vs2), .HREF_cam(href2),
        .frame_cnt(fc2), .frame_done(fd2)
    );

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    task automatic wait_fd(input int which, input int limit, input string name);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            seen = (which == 1) ? fd1 : fd2;
        end
        check(name, int'(seen), 1);
    endtask

    // Monitor: pops one expected byte per HREF-high cycle; blanking must carry 0.
    always @(negedge clk) begin
        logic [7:0] e;
        if (href1 && sb1_on) begin
            if (q1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb1_extra: got byte %02h, expected none queued", data1);
            end else begin
                e = q1.pop_front();
                $display("[%0t] dut1 byte %02h expected %02h", $time, data1, e);
                check("sb1_data", int'(data1), int'(e));
            end
        end
        if (href2 && sb2_on) begin
            if (q2.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb2_extra: got byte %02h, expected none queued", data2);
            end else begin
                e = q2.pop_front();
                $display("[%0t] dut2 byte %02h expected %02h", $time, data2, e);
                check("sb2_data", int'(data2), int'(e));
            end
        end
        if (!href1) check("blank1_zero", int'(data1), 0);
        if (!href2) check("blank2_zero", int'(data2), 0);
    end

    initial begin
        logic [7:0] bars[16];
        int run, nlines;
        int runs[8];
        bit ev, eh, ed;

        bars = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
        rst_n = 1'b0; en1 = 1'b0; en2 = 1'b0; sel1 = 2'd0; sel2 = 2'd0;
        sb1_on = 1'b1; sb2_on = 1'b1;
`ifdef DVP_PATGEN_SHORT_LINE_EN
        inj1 = 1'b0; inj2 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_vsync1", int'(vs1), 0);
        check("rst_href1",  int'(href1), 0);
        check("rst_fcnt1",  int'(fc1), 0);
        check("rst_fdone1", int'(fd1), 0);
        check("rst_vsync2", int'(vs2), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_vsync1", int'(vs1), 0);

        // Frame timing, colour bars and enable drop during line 2.
        for (int y = 0; y < 4; y++)
            for (int b = 0; b < 16; b++) q1.push_back(bars[b]);
        en1 = 1'b1; sel1 = 2'd0;
        @(posedge clk);
        for (int k = 0; k <= 200; k++) begin
            @(negedge clk);
            if (k == 105) en1 = 1'b0;
            ev = (k < 40);
            eh = (k >= 60) && (k < 140) && (((k - 60) % 20) < 16);
            ed = (k == 160);
            check("t1_vs_href_fd", int'({vs1, href1, fd1}), int'({ev, eh, ed}));
            if (k == 160) check("t1_frame_cnt", int'(fc1), 1);
        end
        check("t1_sb_drained", q1.size(), 0);

        // 8-bit ramps; pattern_sel change mid-frame only affects the next frame.
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++) q2.push_back(8'(x));
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++) q2.push_back(8'(y));
        en2 = 1'b1; sel2 = 2'd1;
        @(posedge clk);
        repeat (50) @(negedge clk);
        sel2 = 2'd2;
        wait_fd(2, 200, "t2_fd_a");
        check("t2_fcnt_a", int'(fc2), 1);
        en2 = 1'b0;
        wait_fd(2, 200, "t2_fd_b");
        check("t2_fcnt_b", int'(fc2), 2);
        repeat (3) @(negedge clk);
        check("t2_idle_vs", int'(vs2), 0);
        check("t2_sb_drained", q2.size(), 0);
        for (int i = 0; i < 32; i++) q2.push_back(8'd2);
        sel2 = 2'd3; en2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en2 = 1'b0;
        wait_fd(2, 200, "t2_fd_c");
        check("t2_fcnt_c", int'(fc2), 3);
        check("t2_flat_drained", q2.size(), 0);

        // Asynchronous reset in the middle of an HREF pulse.
        sb1_on = 1'b0;
        en1 = 1'b1; sel1 = 2'd0;
        run = 0;
        while (!href1 && run < 200) begin
            @(negedge clk);
            run++;
        end
        check("t3_href_seen", int'(href1), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t3_rst_vs",    int'(vs1), 0);
        check("t3_rst_href",  int'(href1), 0);
        check("t3_rst_data",  int'(data1), 0);
        check("t3_rst_fdone", int'(fd1), 0);
        check("t3_rst_fcnt",  int'(fc1), 0);
        en1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("t3_idle_vs", int'(vs1), 0);
        check("t3_idle_fcnt", int'(fc1), 0);
        en1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t3_restart_vs", int'(vs1), 1);
        en1 = 1'b0;
        wait_fd(1, 200, "t3_fd");
        check("t3_fcnt", int'(fc1), 1);

`ifdef DVP_PATGEN_SHORT_LINE_EN
        // One shortened line; the frame length must stay 160 cycles.
        @(negedge clk) inj1 = 1'b1;
        @(negedge clk) inj1 = 1'b0;
        en1 = 1'b1;
        @(posedge clk);
        run = 0; nlines = 0;
        for (int k = 0; k <= 160; k++) begin
            @(negedge clk);
            if (k == 1) en1 = 1'b0;
            if (href1) run++;
            else if (run != 0) begin
                if (nlines < 8) runs[nlines] = run;
                nlines++;
                run = 0;
            end
            if (k == 160) check("t5_fd_at_160", int'(fd1), 1);
        end
        check("t5_nlines", nlines, 4);
        check("t5_short_len", runs[0], 14);
        for (int i = 1; i < 4; i++) check("t5_full_len", runs[i], 16);
`endif

        // 256 back-to-back frames: frame_cnt wraps to 0.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        check("t4_fcnt_start", int'(fc1), 0);
        en1 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wait_fd(1, 200, "t4_fd");
            if (i == 254) begin
                check("t4_fcnt_255", int'(fc1), 255);
                en1 = 1'b0;
            end
        end
        check("t4_fcnt_wrap", int'(fc1), 0);
        repeat (5) @(negedge clk);
        check("t4_idle_vs", int'(vs1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
